// File: rtl/adder_rr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_pkg
//  Description : Shared types, constants and the round-robin pick helper for
//                the adder round-robin scheduler.
//                Contents:
//                  OP_W            - operand width of the shared adder
//                  DEFAULT_NUM_REQ - default requester count
//                  MAX_REQ/PICK_W  - widest supported requester vector / index
//                  state_t         - scheduler FSM state encoding
//                  pick_t          - rr_pick result (found flag + index)
//                  rr_pick()       - first set request bit at/after a pointer
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_rr_pkg;

    localparam int OP_W            = 2;
    localparam int DEFAULT_NUM_REQ = 4;
    localparam int MAX_REQ         = 8;
    localparam int PICK_W          = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // Searches req starting at ptr and wrapping modulo n. Only the low n bits
    // of req are considered; callers zero-extend narrower vectors.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [PICK_W-1:0]  ptr,
                                      input int unsigned        n);
        pick_t       p;
        int unsigned k;
        p = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (!p.found && (i < n)) begin
                k = (32'(ptr) + i) % n;
                if (req[k[PICK_W-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = k[PICK_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_rr_scheduler_fa.sv
`default_nettype none
// ============================================================================
//  Module      : Full_Adder_2Bit
//  Description : Two-bit ripple-carry full adder, purely combinational.
//                Ports:
//                  A, B  in  [1:0]  operands
//                  C_in  in         carry-in
//                  S     out [1:0]  sum bits
//                  C_out out        carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module Full_Adder_2Bit (
    input  logic [1:0] A,
    input  logic [1:0] B,
    input  logic       C_in,
    output logic [1:0] S,
    output logic       C_out
);

    logic w_c0;

    always_comb begin
        S[0]  = A[0] ^ B[0] ^ C_in;
        w_c0  = (A[0] & B[0]) | (A[0] & C_in) | (B[0] & C_in);
        S[1]  = A[1] ^ B[1] ^ w_c0;
        C_out = (A[1] & B[1]) | (A[1] & w_c0) | (B[1] & w_c0);
    end

endmodule
`default_nettype wire

// File: rtl/adder_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : adder_rr_scheduler
//  Description : Shares one 2-bit full adder among NUM_REQ requesters with
//                round-robin arbitration; returns tagged results through a
//                valid/ready response port.
//                Ports:
//                  clk, rst             clock, synchronous active-high reset
//                  req     [N-1:0]      pending-request vector
//                  op_a    [2N-1:0]     packed operand A (req i: [2i+1:2i])
//                  op_b    [2N-1:0]     packed operand B
//                  op_cin  [N-1:0]      carry-in per requester
//                  gnt     [N-1:0]      one-hot grant, one cycle per accept
//                  res_valid/res_ready  response handshake
//                  res_id  [ID_W-1:0]   owner of the result
//                  res_sum [1:0], res_cout  registered adder result
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_scheduler
    import adder_rr_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*OP_W-1:0]   op_a,
    input  logic [NUM_REQ*OP_W-1:0]   op_b,
    input  logic [NUM_REQ-1:0]        op_cin,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic [OP_W-1:0]           res_sum,
    output logic                      res_cout
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [ID_W-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [OP_W-1:0]      a_q,         a_d;
    logic [OP_W-1:0]      b_q,         b_d;
    logic                 cin_q,       cin_d;
    logic [ID_W-1:0]      win_id_q,    win_id_d;
    logic [NUM_REQ-1:0]   gnt_q,       gnt_d;
    logic                 res_valid_q, res_valid_d;
    logic [ID_W-1:0]      res_id_q,    res_id_d;
    logic [OP_W-1:0]      res_sum_q,   res_sum_d;
    logic                 res_cout_q,  res_cout_d;

    // ------------------------------------------------------------------
    // Arbitration and operand selection
    // ------------------------------------------------------------------
    logic [MAX_REQ-1:0]   w_req_ext;
    logic [PICK_W-1:0]    w_ptr_ext;
    pick_t                w_pick;
    logic [OP_W-1:0]      w_sel_a;
    logic [OP_W-1:0]      w_sel_b;
    logic                 w_sel_cin;
    logic [ID_W-1:0]      w_win_id;
    logic [NUM_REQ-1:0]   w_win_onehot;

    always_comb begin
        w_req_ext                  = '0;
        w_req_ext[NUM_REQ-1:0]     = req;
        w_ptr_ext                  = '0;
        w_ptr_ext[ID_W-1:0]        = rr_ptr_q;
        w_pick                     = rr_pick(w_req_ext, w_ptr_ext, NUM_REQ);
    end

    // Decode the winning index into a mux select; doing it by comparison keeps
    // the full-width pick index in use regardless of NUM_REQ.
    always_comb begin
        w_sel_a      = '0;
        w_sel_b      = '0;
        w_sel_cin    = 1'b0;
        w_win_id     = '0;
        w_win_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick.idx == PICK_W'(i)) begin
                w_sel_a         = op_a[i*OP_W +: OP_W];
                w_sel_b         = op_b[i*OP_W +: OP_W];
                w_sel_cin       = op_cin[i];
                w_win_id        = ID_W'(i);
                w_win_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared adder, driven only from the operand latches
    // ------------------------------------------------------------------
    logic [OP_W-1:0] w_add_s;
    logic            w_add_cout;

    Full_Adder_2Bit u_adder (
        .A     (a_q),
        .B     (b_q),
        .C_in  (cin_q),
        .S     (w_add_s),
        .C_out (w_add_cout)
    );

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        cin_d       = cin_q;
        win_id_d    = win_id_q;
        gnt_d       = gnt_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;

        case (state_q)
            IDLE: begin
                if (w_pick.found) begin
                    a_d      = w_sel_a;
                    b_d      = w_sel_b;
                    cin_d    = w_sel_cin;
                    win_id_d = w_win_id;
                    gnt_d    = w_win_onehot;
                    rr_ptr_d = (w_win_id == LAST_ID) ? '0 : w_win_id + ID_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                gnt_d       = '0;
                res_sum_d   = w_add_s;
                res_cout_d  = w_add_cout;
                res_id_d    = win_id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Requests seen here are left pending; they are sampled in
                // the IDLE cycle that follows acceptance.
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                gnt_d       = '0;
                res_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            win_id_q    <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            win_id_q    <= win_id_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign res_cout  = res_cout_q;

endmodule
`default_nettype wire
